// File: rtl/mod_reducer_p.sv
// mod_reducer_p: constant-time serial modular reduction, dout = din mod m.
// One operand bit is folded into the accumulator per cycle, MSB first, so
// every non-zero-modulus operation takes exactly DIN_W+2 cycles.
module mod_reducer_p #(
  parameter int DIN_W = 512,
  parameter int MOD_W = 253,
  parameter logic [MOD_W-1:0] MOD_DEFAULT =
    MOD_W'(253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIN_W-1:0] din,
  input  logic             use_default,
  input  logic [MOD_W-1:0] mod_in,
  output logic [MOD_W-1:0] dout,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             ready
);

  localparam int CNT_W = (DIN_W > 2) ? $clog2(DIN_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t             state;
  logic [DIN_W-1:0]   opnd;
  logic [MOD_W-1:0]   modv;
  logic [MOD_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               err_pend;
  logic [MOD_W-1:0]   m_sel;

  // One reduction step: t = 2*acc + bit is at most 2m-1 because acc < m,
  // so a single conditional subtract restores acc < m. The difference is
  // below m, hence the low MOD_W bits of t-m are exact.
  function automatic logic [MOD_W-1:0] mod_step(input logic [MOD_W-1:0] a,
                                                input logic             b,
                                                input logic [MOD_W-1:0] m);
    logic [MOD_W:0] t;
    t = {a, b};
    if (t >= {1'b0, m})
      return t[MOD_W-1:0] - m;
    else
      return t[MOD_W-1:0];
  endfunction

  // Modulus chosen for a request presented this cycle.
  always_comb begin
    m_sel = use_default ? MOD_DEFAULT : mod_in;
  end

  // Control FSM and datapath: capture, serial reduce, publish result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      dout     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      opnd     <= '0;
      modv     <= '0;
      err_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opnd     <= din;
            modv     <= m_sel;
            acc      <= '0;
            cnt      <= CNT_W'(DIN_W - 1);
            err_pend <= (m_sel == '0);
            state    <= (m_sel == '0) ? FINAL : RUN;
          end
        end
        RUN: begin
          acc  <= mod_step(acc, opnd[DIN_W-1], modv);
          opnd <= opnd << 1;
          if (cnt == '0)
            state <= FINAL;
          else
            cnt <= cnt - 1'b1;
        end
        FINAL: begin
          dout  <= err_pend ? '0 : acc;
          done  <= 1'b1;
          err   <= err_pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake status follows the state register directly.
  always_comb begin
    busy  = (state != IDLE);
    ready = ~busy;
  end

endmodule

// File: tb/tb_mod_reducer_p.sv
// Testbench for mod_reducer_p: a narrow instance (16-bit operand, 8-bit
// modulus) for bulk random and handshake scenarios, and a default-width
// instance for the Ed25519 group-order cases and mid-operation reset.
module tb_mod_reducer_p;

  localparam logic [252:0] L =
    253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
  localparam logic [7:0] S_DEF = 8'd239;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // narrow instance
  logic        s_rst, s_start, s_ud;
  logic [15:0] s_din;
  logic [7:0]  s_mod, s_dout;
  logic        s_done, s_err, s_busy, s_ready;

  // default-width instance
  logic         w_rst, w_start, w_ud;
  logic [511:0] w_din;
  logic [252:0] w_mod, w_dout;
  logic         w_done, w_err, w_busy, w_ready;

  mod_reducer_p #(.DIN_W(16), .MOD_W(8), .MOD_DEFAULT(S_DEF)) u_s (
    .clk(clk), .rst(s_rst), .start(s_start), .din(s_din),
    .use_default(s_ud), .mod_in(s_mod), .dout(s_dout), .done(s_done),
    .err(s_err), .busy(s_busy), .ready(s_ready)
  );

  mod_reducer_p u_w (
    .clk(clk), .rst(w_rst), .start(w_start), .din(w_din),
    .use_default(w_ud), .mod_in(w_mod), .dout(w_dout), .done(w_done),
    .err(w_err), .busy(w_busy), .ready(w_ready)
  );

  // Reference: plain modular arithmetic on the selected modulus.
  function automatic void ref_s(input logic [15:0] d, input logic ud,
                                input logic [7:0] m, output logic [7:0] q,
                                output logic e, output int lat);
    logic [7:0] mm;
    mm = ud ? S_DEF : m;
    if (mm == 8'd0) begin
      q = 8'd0; e = 1'b1; lat = 1;
    end else begin
      q = 8'(d % mm); e = 1'b0; lat = 17;
    end
  endfunction

  function automatic logic [252:0] ref_w(input logic [511:0] d);
    logic [511:0] r;
    r = d % {259'd0, L};
    return r[252:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  // Issue one request on the narrow DUT (which must be idle) and wait for done.
  task automatic run_s(input logic [15:0] d, input logic ud, input logic [7:0] m,
                       input bit scramble, output logic [7:0] q,
                       output logic e, output int lat);
    s_din = d; s_ud = ud; s_mod = m; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (scramble) begin
        s_din = 16'($urandom); s_mod = 8'($urandom);
        s_ud = 1'($urandom); s_start = 1'($urandom);
      end
      @(posedge clk); #1;
      if (s_done) begin
        lat = k;
        break;
      end
    end
    s_start = 1'b0;
    q = s_dout; e = s_err;
  endtask

  task automatic run_w(input logic [511:0] d, input logic ud, input logic [252:0] m,
                       output logic [252:0] q, output logic e, output int lat);
    w_din = d; w_ud = ud; w_mod = m; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    w_din = rand512();
    lat = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #1;
      if (w_done) begin
        lat = k;
        break;
      end
    end
    q = w_dout; e = w_err;
  endtask

  task automatic test_reset();
    s_rst = 1'b0; w_rst = 1'b0; s_start = 1'b1; w_start = 1'b1;
    s_din = 16'hFFFF; s_ud = 1'b0; s_mod = 8'd7;
    w_din = '1; w_ud = 1'b1; w_mod = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_dout, s_done, s_err, s_busy, s_ready} !== {8'd0, 4'b0001}) begin
      fails++;
      $display("FAIL reset_s: got dout=%h done=%b err=%b busy=%b ready=%b, want 0/0/0/0/1",
               s_dout, s_done, s_err, s_busy, s_ready);
    end
    checks++;
    if ({w_dout, w_done, w_err, w_busy, w_ready} !== {253'd0, 4'b0001}) begin
      fails++;
      $display("FAIL reset_w: got done=%b err=%b busy=%b ready=%b dout=%h",
               w_done, w_err, w_busy, w_ready, w_dout);
    end
    s_start = 1'b0; w_start = 1'b0; s_rst = 1'b1; w_rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_busy, w_busy, s_done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_start_ignored: got busy_s=%b busy_w=%b done=%b, want 000",
               s_busy, w_busy, s_done);
    end
  endtask

  task automatic test_directed();
    logic [7:0] q; logic e; int lat;
    run_s(16'hFFFF, 1'b0, 8'd251, 1'b0, q, e, lat);
    checks++;
    if ({q, e} !== {8'd24, 1'b0} || lat != 17) begin
      fails++;
      $display("FAIL ffff_mod251: got %0d err=%b lat=%0d, want 24 err=0 lat=17", q, e, lat);
    end
    run_s(16'd250, 1'b0, 8'd251, 1'b0, q, e, lat);
    checks++;
    if ({q, e} !== {8'd250, 1'b0} || lat != 17) begin
      fails++;
      $display("FAIL 250_mod251: got %0d err=%b lat=%0d, want 250 err=0 lat=17", q, e, lat);
    end
    run_s(16'd50000, 1'b1, 8'd0, 1'b0, q, e, lat);
    checks++;
    if ({q, e} !== {8'(50000 % 239), 1'b0} || lat != 17) begin
      fails++;
      $display("FAIL use_default_s: got %0d err=%b lat=%0d, want %0d", q, e, lat, 50000 % 239);
    end
  endtask

  task automatic test_zero_mod();
    logic [7:0] q; logic e; int lat;
    run_s(16'($urandom), 1'b0, 8'd0, 1'b0, q, e, lat);
    checks++;
    if ({q, e} !== {8'd0, 1'b1} || lat != 1) begin
      fails++;
      $display("FAIL mod_zero: got %0d err=%b lat=%0d, want 0 err=1 lat=1", q, e, lat);
    end
    run_s(16'($urandom), 1'b0, 8'd1, 1'b0, q, e, lat);
    checks++;
    if ({q, e} !== {8'd0, 1'b0} || lat != 17) begin
      fails++;
      $display("FAIL mod_one: got %0d err=%b lat=%0d, want 0 err=0 lat=17", q, e, lat);
    end
  endtask

  task automatic test_wide_default();
    logic [252:0] q; logic e; int lat;
    logic [511:0] d;
    logic [511:0] vec [4];
    vec[0] = '0;
    vec[1] = {259'd0, L};
    vec[2] = {259'd0, L} + 512'd5;
    vec[3] = rand512();
    for (int i = 0; i < 4; i++) begin
      d = vec[i];
      run_w(d, 1'b1, 253'($urandom), q, e, lat);
      checks++;
      if ({q, e} !== {ref_w(d), 1'b0} || lat != 513) begin
        fails++;
        $display("FAIL wide_default[%0d]: got %h err=%b lat=%0d, want %h lat=513",
                 i, q, e, lat, ref_w(d));
      end
    end
    checks++;
    if (ref_w(vec[2]) !== 253'd5) begin
      fails++;
      $display("FAIL wide_model_sanity: got %h, want 5", ref_w(vec[2]));
    end
  endtask

  task automatic test_mid_reset();
    logic [252:0] q; logic e; int lat; int ndone;
    w_din = rand512(); w_ud = 1'b1; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    ndone = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (w_done) ndone++;
    end
    checks++;
    if ({w_busy, w_ready} !== 2'b10) begin
      fails++;
      $display("FAIL busy_in_run: got busy=%b ready=%b, want 1/0", w_busy, w_ready);
    end
    w_rst = 1'b0;
    @(posedge clk); #1;
    w_rst = 1'b1;
    checks++;
    if ({w_busy, w_ready, w_done, w_err} !== 4'b0100 || w_dout !== 253'd0) begin
      fails++;
      $display("FAIL mid_reset_state: got busy=%b ready=%b done=%b err=%b dout=%h",
               w_busy, w_ready, w_done, w_err, w_dout);
    end
    repeat (600) begin
      @(posedge clk); #1;
      if (w_done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL mid_reset_no_done: got %0d done pulses, want 0", ndone);
    end
    run_w({259'd0, L} + 512'd5, 1'b1, '0, q, e, lat);
    checks++;
    if ({q, e} !== {253'd5, 1'b0} || lat != 513) begin
      fails++;
      $display("FAIL after_mid_reset: got %h err=%b lat=%0d, want 5 lat=513", q, e, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expq[$];
    logic [7:0] exp_v;
    int last, cyc, got;
    last = -1; cyc = 0; got = 0;
    s_ud = 1'b0; s_mod = 8'd251;
    s_din = 16'($urandom);
    expq.push_back(8'(s_din % 251));
    s_start = 1'b1;
    while (got < 6 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (s_done) begin
        exp_v = expq.pop_front();
        checks++;
        if (s_dout !== exp_v) begin
          fails++;
          $display("FAIL b2b_value[%0d]: got %0d, want %0d", got, s_dout, exp_v);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 18) begin
            fails++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 18", got, cyc - last);
          end
        end
        last = cyc;
        got++;
        s_din = 16'($urandom);
        expq.push_back(8'(s_din % 251));
      end else begin
        s_din = 16'($urandom);
      end
    end
    s_start = 1'b0;
    checks++;
    if (got != 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d results, want 6", got);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] d; logic ud; logic [7:0] m;
    logic [7:0] q, eq; logic e, ee; int lat, el;
    for (int i = 0; i < 2000; i++) begin
      d  = 16'($urandom);
      ud = 1'($urandom);
      m  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      run_s(d, ud, m, 1'b1, q, e, lat);
      ref_s(d, ud, m, eq, ee, el);
      checks++;
      if ({q, e} !== {eq, ee} || lat != el) begin
        fails++;
        $display("FAIL random[%0d] din=%0d ud=%b m=%0d: got %0d err=%b lat=%0d, want %0d err=%b lat=%0d",
                 i, d, ud, m, q, e, lat, eq, ee, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_mod();
    test_wide_default();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
